// File: rtl/fila_serializer.sv
// Drains the byte queue and sends each word LSB-first as write_out/data_out bit strobes; registered outputs.
// Per byte: 2 + WIDTH*(1+GAP_CYCLES) cycles; pops only while enabled and the queue is non-empty.
module fila_serializer #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk_1MHz,
  input  logic             reset,
  input  logic             enable_in,
  input  logic [WIDTH-1:0] fila_data_in,
  input  logic [7:0]       fila_len_in,
  output logic             dequeue_out,
  output logic             data_out,
  output logic             write_out,
  output logic             busy_out,
  output logic [7:0]       sent_count_out
);

  localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);
  localparam logic [3:0]     GAP_LOAD = 4'(GAP_CYCLES);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    BIT_HI = 3'd2,
    BIT_LO = 3'd3,
    SETTLE = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [3:0]       gap_q, gap_d;
  logic             dequeue_q, dequeue_d;
  logic             data_q, data_d;
  logic             write_q, write_d;
  logic             busy_q, busy_d;
  logic [7:0]       sent_q, sent_d;
  logic [CW-1:0]    next_bit;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_d     = gap_q;
    dequeue_d = 1'b0;
    data_d    = data_q;
    write_d   = 1'b0;
    sent_d    = sent_q;
    next_bit  = bit_cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        // Word is captured on the same edge the pop is issued.
        if (enable_in && (fila_len_in != 8'd0)) begin
          state_d   = LOAD;
          shreg_d   = fila_data_in;
          dequeue_d = 1'b1;
          bit_cnt_d = '0;
        end
      end
      LOAD: begin
        state_d = BIT_HI;
        data_d  = shreg_q[bit_cnt_q];
        write_d = 1'b1;
      end
      BIT_HI: begin
        state_d = BIT_LO;
        gap_d   = GAP_LOAD;
      end
      BIT_LO: begin
        if (gap_q <= 4'd1) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d = SETTLE;
            sent_d  = sent_q + 8'd1;
          end else begin
            state_d   = BIT_HI;
            bit_cnt_d = next_bit;
            data_d    = shreg_q[next_bit];
            write_d   = 1'b1;
          end
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      // One spare cycle so the queue length reflects the pop before IDLE looks again.
      SETTLE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_1MHz or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      gap_q     <= '0;
      dequeue_q <= 1'b0;
      data_q    <= 1'b0;
      write_q   <= 1'b0;
      busy_q    <= 1'b0;
      sent_q    <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      gap_q     <= gap_d;
      dequeue_q <= dequeue_d;
      data_q    <= data_d;
      write_q   <= write_d;
      busy_q    <= busy_d;
      sent_q    <= sent_d;
    end
  end

  assign dequeue_out    = dequeue_q;
  assign data_out       = data_q;
  assign write_out      = write_q;
  assign busy_out       = busy_q;
  assign sent_count_out = sent_q;

endmodule

// File: tb/tb_fila_serializer.sv
// Directed bench: queue model feeding a GAP_CYCLES=1 serializer, plus a GAP_CYCLES=3 instance.
`timescale 1ns/1ps
module tb_fila_serializer;

  logic clk = 1'b0;
  logic rst;

  logic       en_a;
  logic [7:0] data_a, len_a;
  logic       deq_a, dout_a, wr_a, busy_a;
  logic [7:0] cnt_a;

  logic       en_b;
  logic [7:0] data_b, len_b;
  logic       deq_b, dout_b, wr_b, busy_b;
  logic [7:0] cnt_b;

  logic [7:0] mem [0:511];
  int q_wr = 0;
  int q_rd = 0;

  assign len_a  = 8'(q_wr - q_rd);
  assign data_a = mem[9'(q_rd)];

  fila_serializer #(.WIDTH(8), .GAP_CYCLES(1)) dut_a (
    .clk_1MHz(clk), .reset(rst), .enable_in(en_a), .fila_data_in(data_a),
    .fila_len_in(len_a), .dequeue_out(deq_a), .data_out(dout_a),
    .write_out(wr_a), .busy_out(busy_a), .sent_count_out(cnt_a)
  );

  fila_serializer #(.WIDTH(8), .GAP_CYCLES(3)) dut_b (
    .clk_1MHz(clk), .reset(rst), .enable_in(en_b), .fila_data_in(data_b),
    .fila_len_in(len_b), .dequeue_out(deq_b), .data_out(dout_b),
    .write_out(wr_b), .busy_out(busy_b), .sent_count_out(cnt_b)
  );

  always #500 clk = ~clk;

  int   cyc = 0;
  int   deq_a_c[$];
  int   wr_a_c[$];
  logic wr_a_b[$];
  int   busy_a_n = 0;
  int   deq_b_c[$];
  int   wr_b_c[$];
  logic wr_b_b[$];
  int   busy_b_n = 0;

  // Event log and queue pop model, sampled on the falling edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (deq_a) begin
      deq_a_c.push_back(cyc);
      q_rd <= q_rd + 1;
    end
    if (wr_a) begin
      wr_a_c.push_back(cyc);
      wr_a_b.push_back(dout_a);
    end
    if (busy_a) busy_a_n <= busy_a_n + 1;
    if (deq_b) deq_b_c.push_back(cyc);
    if (wr_b) begin
      wr_b_c.push_back(cyc);
      wr_b_b.push_back(dout_b);
    end
    if (busy_b) busy_b_n <= busy_b_n + 1;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    mem[9'(q_wr)] = v;
    q_wr++;
  endtask

  function automatic logic [7:0] byte_a(input int idx);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = wr_a_b[idx + i];
    return b;
  endfunction

  initial begin
    int d0, w0, b0, bad;
    logic [7:0] bb;

    rst = 1'b1; en_a = 1'b1; en_b = 1'b0; len_b = 8'd0; data_b = 8'd0;
    push(8'hAB); push(8'h5A); push(8'h3C);

    // Reset held 2 us with a non-empty queue and enable high.
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_outs_a", 32'({deq_a, wr_a, dout_a, busy_a, cnt_a}), 32'd0);
      check("rst_outs_b", 32'({deq_b, wr_b, dout_b, busy_b, cnt_b}), 32'd0);
    end
    check("rst_no_pop", 32'(len_a), 32'd3);

    en_a = 1'b0; rst = 1'b0;
    repeat (10) tick();
    check("dis_no_deq", 32'(deq_a_c.size()), 32'd0);
    check("dis_busy", 32'(busy_a), 32'd0);
    check("dis_len", 32'(len_a), 32'd3);

    // Single byte 8'hAB, enable pulsed for one cycle only.
    d0 = deq_a_c.size(); w0 = wr_a_c.size(); b0 = busy_a_n;
    en_a = 1'b1; tick(); en_a = 1'b0;
    repeat (30) tick();
    check("single_deq", 32'(deq_a_c.size() - d0), 32'd1);
    check("single_wr", 32'(wr_a_c.size() - w0), 32'd8);
    check("single_bits", 32'(byte_a(w0)), 32'h0AB);
    check("single_first_wr", 32'(wr_a_c[w0] - deq_a_c[d0]), 32'd1);
    bad = 0;
    for (int k = 1; k < 8; k++) if (wr_a_c[w0 + k] - wr_a_c[w0 + k - 1] != 2) bad++;
    check("single_spacing", 32'(bad), 32'd0);
    check("single_busy", 32'(busy_a_n - b0), 32'd18);
    check("single_cnt", 32'(cnt_a), 32'd1);
    check("single_len", 32'(len_a), 32'd2);

    // Enable dropped after the 3rd strobe: byte finishes, nothing else starts.
    d0 = deq_a_c.size(); w0 = wr_a_c.size();
    en_a = 1'b1;
    for (int i = 0; i < 40 && wr_a_c.size() < w0 + 3; i++) tick();
    check("drop_wait", 32'(wr_a_c.size() >= w0 + 3), 32'd1);
    en_a = 1'b0;
    repeat (30) tick();
    check("drop_deq", 32'(deq_a_c.size() - d0), 32'd1);
    check("drop_wr", 32'(wr_a_c.size() - w0), 32'd8);
    check("drop_bits", 32'(byte_a(w0)), 32'h05A);
    check("drop_cnt", 32'(cnt_a), 32'd2);
    check("drop_len", 32'(len_a), 32'd1);

    // Back-to-back: four queued bytes.
    push(8'hAB); push(8'h01); push(8'h80);
    d0 = deq_a_c.size(); w0 = wr_a_c.size();
    en_a = 1'b1;
    for (int i = 0; i < 120 && !(len_a == 8'd0 && !busy_a); i++) tick();
    check("b2b_drained", 32'(len_a == 8'd0 && !busy_a), 32'd1);
    repeat (5) tick();
    check("b2b_deq", 32'(deq_a_c.size() - d0), 32'd4);
    bad = 0;
    for (int k = 1; k < 4; k++) if (deq_a_c[d0 + k] - deq_a_c[d0 + k - 1] != 19) bad++;
    check("b2b_spacing", 32'(bad), 32'd0);
    check("b2b_byte0", 32'(byte_a(w0)), 32'h03C);
    check("b2b_byte1", 32'(byte_a(w0 + 8)), 32'h0AB);
    check("b2b_byte2", 32'(byte_a(w0 + 16)), 32'h001);
    check("b2b_byte3", 32'(byte_a(w0 + 24)), 32'h080);
    check("b2b_cnt", 32'(cnt_a), 32'd6);

    // Empty queue with enable high.
    d0 = deq_a_c.size(); w0 = wr_a_c.size();
    repeat (50) tick();
    check("empty_deq", 32'(deq_a_c.size() - d0), 32'd0);
    check("empty_wr", 32'(wr_a_c.size() - w0), 32'd0);

    // Reset after the 4th strobe of a byte.
    d0 = deq_a_c.size(); w0 = wr_a_c.size();
    push(8'hD2); push(8'h4B);
    for (int i = 0; i < 40 && wr_a_c.size() < w0 + 4; i++) tick();
    check("mid_wait", 32'(wr_a_c.size() >= w0 + 4), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_outs", 32'({deq_a, wr_a, dout_a, busy_a, cnt_a}), 32'd0);
    check("mid_len", 32'(len_a), 32'd1);
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 60 && !(len_a == 8'd0 && !busy_a); i++) tick();
    check("mid_drained", 32'(len_a == 8'd0 && !busy_a), 32'd1);
    check("mid_deq", 32'(deq_a_c.size() - d0), 32'd2);
    check("mid_cnt", 32'(cnt_a), 32'd1);
    check("mid_bits", 32'(byte_a(wr_a_c.size() - 8)), 32'h04B);

    // Counter wrap over 256 bytes.
    en_a = 1'b0; rst = 1'b1; tick(); rst = 1'b0; tick();
    check("wrap_start", 32'(cnt_a), 32'd0);
    for (int i = 0; i < 200; i++) push(8'(i));
    en_a = 1'b1;
    for (int i = 0; i < 4200 && cnt_a != 8'd200; i++) tick();
    check("wrap_200", 32'(cnt_a), 32'd200);
    for (int i = 0; i < 56; i++) push(8'(i + 200));
    for (int i = 0; i < 1200 && cnt_a != 8'd255; i++) tick();
    check("wrap_255", 32'(cnt_a), 32'd255);
    for (int i = 0; i < 40 && cnt_a == 8'd255; i++) tick();
    check("wrap_0", 32'(cnt_a), 32'd0);
    for (int i = 0; i < 40 && busy_a; i++) tick();
    check("wrap_len", 32'(len_a), 32'd0);

    // GAP_CYCLES = 3 instance: one byte 8'hC3.
    d0 = deq_b_c.size(); w0 = wr_b_c.size(); b0 = busy_b_n;
    data_b = 8'hC3; len_b = 8'd1; en_b = 1'b1;
    for (int i = 0; i < 10 && deq_b_c.size() == d0; i++) tick();
    check("g3_deq_seen", 32'(deq_b_c.size() - d0), 32'd1);
    len_b = 8'd0; en_b = 1'b0;
    repeat (45) tick();
    check("g3_deq", 32'(deq_b_c.size() - d0), 32'd1);
    check("g3_wr", 32'(wr_b_c.size() - w0), 32'd8);
    bb = 8'd0;
    for (int i = 0; i < 8; i++) bb[i] = wr_b_b[w0 + i];
    check("g3_bits", 32'(bb), 32'h0C3);
    check("g3_first_wr", 32'(wr_b_c[w0] - deq_b_c[d0]), 32'd1);
    bad = 0;
    for (int k = 1; k < 8; k++) if (wr_b_c[w0 + k] - wr_b_c[w0 + k - 1] != 4) bad++;
    check("g3_spacing", 32'(bad), 32'd0);
    check("g3_busy", 32'(busy_b_n - b0), 32'd34);
    check("g3_cnt", 32'(cnt_b), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fila_serializer.md
# fila_serializer

Downstream drain stage for the byte queue: while enabled, pops one byte at a time from the queue head and retransmits it LSB-first on a bit-serial output. It uses the same bit/strobe framing the deserializer accepts on its input, so a loopback chain can be formed. It sits after the queue in the Top datapath and drives the queue's dequeue input.

## Interface
- WIDTH, 8: bits per queue word; also the number of serial bits per byte.
- GAP_CYCLES, 1: idle cycles with write_out low after each write_out strobe; legal range is 1..15.
- clk_1MHz  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state and outputs immediately.
- enable_in  input  1  permits starting a new byte; sampled only in IDLE.
- fila_data_in  input  WIDTH  queue head word; valid when fila_len_in != 0.
- fila_len_in  input  8  queue occupancy.
- dequeue_out  output  1  one-cycle pulse that removes the queue head.
- data_out  output  1  serial data bit; valid while write_out = 1 and held until the next bit.
- write_out  output  1  one-cycle strobe per serial bit.
- busy_out  output  1  high in every state except IDLE.
- sent_count_out  output  8  count of fully transmitted bytes; wraps 255 -> 0.

## Operation
- All outputs are registered.
- Reset value of every output and internal register is 0; state after reset is IDLE.
- States and transitions:
  - IDLE -> LOAD when enable_in = 1 and fila_len_in != 0; otherwise stay in IDLE.
  - LOAD -> BIT_HI unconditionally.
  - BIT_HI -> BIT_LO unconditionally.
  - BIT_LO -> BIT_HI after GAP_CYCLES cycles if bit_cnt < WIDTH-1.
  - BIT_LO -> SETTLE after GAP_CYCLES cycles if bit_cnt = WIDTH-1.
  - SETTLE -> IDLE unconditionally.
- On the IDLE->LOAD edge: shreg <= fila_data_in, dequeue_out <= 1, bit_cnt <= 0. The word is captured before the pop.
- Entering BIT_HI: data_out <= shreg[bit_cnt], write_out <= 1. Bits go out LSB first.
- Entering BIT_LO: write_out <= 0; data_out holds its value; the gap counter loads GAP_CYCLES.
- Leaving BIT_LO for BIT_HI: bit_cnt increments.
- Leaving BIT_LO for SETTLE: sent_count_out increments (modulo 256).
- SETTLE is one cycle. It lets fila_len_in reflect the pop before IDLE re-evaluates it.
- enable_in falling mid-byte does not abort; the current byte completes.
- fila_data_in and fila_len_in are ignored outside IDLE.
- Reset mid-byte: all outputs go to 0 at once and the partially sent byte is lost; it was already dequeued. No second dequeue occurs.
- The block never issues dequeue_out while fila_len_in = 0, so an empty queue is never popped.

## Timing
- dequeue_out is high for exactly one cycle per byte, in the cycle right after IDLE samples the start condition.
- First write_out rises 1 cycle after dequeue_out rises.
- Bit period is 1 + GAP_CYCLES cycles; write_out is high 1 cycle of each period.
- Byte duration from the rise of dequeue_out to the return to IDLE is 2 + WIDTH*(1+GAP_CYCLES) cycles, i.e. 18 at defaults.
- Minimum dequeue_out-to-dequeue_out spacing with the queue kept non-empty is 3 + WIDTH*(1+GAP_CYCLES) cycles, i.e. 19 at defaults.
- busy_out rises with dequeue_out and falls when the block re-enters IDLE.

## Test plan
- Reset behaviour: hold reset 2 us with fila_len_in = 3, enable_in = 1 -> all outputs are 0 throughout and no dequeue_out occurs.
- Single byte: queue holds 8'hAB, enable_in = 1 -> one dequeue_out pulse, then 8 write_out strobes 2 cycles apart carrying 1,1,0,1,0,1,0,1. sent_count_out = 1. busy_out is high for 18 cycles.
- Back-to-back: 4 bytes 8'hAB queued -> exactly 4 dequeue_out pulses spaced 19 cycles apart. sent_count_out ends at 4 and fila_len_in reaches 0. A loopback into the deserializer leaves its status_out at 0.
- Empty and disabled cases:
  - fila_len_in = 0 with enable_in = 1 for 50 cycles -> no dequeue_out and no write_out.
  - enable_in = 0 with fila_len_in = 2 -> idle.
  - enable_in dropped after the 3rd bit -> the byte completes and no next byte starts.
- Reset mid-byte: assert reset after the 4th strobe -> outputs are 0 immediately. After release, a new byte starts only if the queue is non-empty; there is no duplicate pop.
- Counter wrap: transmit 256 bytes -> sent_count_out goes 255 -> 0. Repeat with GAP_CYCLES = 3 -> strobes are 4 cycles apart.
